terminal_char_sender: RTL and testbench
=======================================

Name: terminal_char_sender

Overview:
- Host-side transmitter for the video terminal's character input port.
- Accepts 7-bit ASCII characters from a producer (keyboard/UART bridge/CPU port) into a small FIFO.
- Presents each character on rd_out[7:1] with the DA strobe, paced by the terminal's RDA ready flag, one character at a time.
- Sits between the character source and the video_terminal rd_in/da_in inputs.

Parameters:
- FIFO_DEPTH, 16, character FIFO entries; power of two, 2..256.
- SETUP_CYCLES, 2, clocks rd_out is stable before da_out rises; 1..15.
- ACK_TIMEOUT, 4096, clocks to wait in STROBE for the terminal to drop RDA before forcing release; at least 2.
- UPCASE, 1, when 1 map ASCII 0x61-0x7A to 0x41-0x5A on FIFO write.

Ports:
- clk  input  1  system clock, single domain.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  producer write strobe, one character per asserted cycle.
- wr_data  input  7  ASCII character to enqueue.
- full  output  1  FIFO full; writes while full are dropped.
- overflow  output  1  sticky; set on a write while full; cleared only by rst.
- rda_in  input  1  terminal ready, high = idle/able to accept; asynchronous to the sender FSM.
- rd_out  output  7  character to terminal, bit 6 = rd[7].
- da_out  output  1  data-available strobe to terminal.
- busy  output  1  high when FSM is not IDLE or FIFO is non-empty.
- timeout  output  1  one-cycle pulse when the ACK_TIMEOUT counter expires.

Behaviour:
- Reset values: rd_out=0, da_out=0, full=0, overflow=0, busy=0, timeout=0. FIFO emptied, FSM in IDLE, counters cleared, rda sync flops cleared.
- rst mid-transfer aborts the transfer: da_out drops the cycle after rst is sampled, and the pending character is discarded.
- rda_in passes through a 2-flop synchronizer; rda_s is the synchronized value. Response latency to rda_in is 2 clocks plus the FSM register.
- FIFO:
  - Synchronous, first-word fall-through not required.
  - Simultaneous write and pop when full: the pop frees a slot first, and the write is accepted.
  - Simultaneous write and pop when empty: the write is accepted, and the pop does not occur that cycle.
  - Pointers wrap modulo FIFO_DEPTH. The count register is clog2(FIFO_DEPTH)+1 bits.
- UPCASE conversion happens before storage (subtract 0x20). Other codes are stored unchanged, including 0x0D CR and 0x7F.
- FSM states:
  - IDLE: if FIFO non-empty and rda_s=1, pop, load rd_out, clear counter, go to SETUP. da_out=0.
  - SETUP: rd_out held. After SETUP_CYCLES clocks, go to STROBE.
  - STROBE: da_out=1 and rd_out held. If rda_s=0 (terminal accepted), go to RELEASE. If the counter reaches ACK_TIMEOUT-1, pulse timeout and go to RELEASE.
  - RELEASE: da_out=0 and rd_out held. Wait for rda_s=1, then go to IDLE.
- RELEASE after a timeout does not wait forever: if rda_s is already 1, it exits in one cycle.
- rd_out never changes while da_out=1.
- Minimum character period with an ideal terminal is SETUP_CYCLES + 2 sync + 3 clocks.
- da_out is registered and glitch-free.

Decomposition:
- Shared package terminal_pkg holds:
  - sender FSM state encoding (IDLE, SETUP, STROBE, RELEASE; 2 bits);
  - ASCII constants: CR=0x0D, LOWER_A=0x61, LOWER_Z=0x7A, CASE_OFFSET=0x20;
  - character width constant CHAR_W=7.
- One sub-module, char_fifo: parameterised synchronous FIFO with push, pop, dout, empty, full and count.
- Synchronizer and FSM live in terminal_char_sender.

Test Plan:
- Reset, then write 0x41 with rda_in=1 held. Required: after SETUP, rd_out=0x41 and da_out=1. Drop rda_in for 10 clocks. Required: da_out falls within 3 clocks of the drop, then busy=0.
- UPCASE=1, write 0x61 then 0x7A. Required: terminal sees 0x41 then 0x5A, in order. Write 0x7B. Required: it is sent as 0x7B.
- Burst-write 17 characters 0x30..0x40 with rda_in=0 and FIFO_DEPTH=16. Required: full=1 after 16 writes and overflow=1 after the 17th. Release rda_in. Required: exactly 0x30..0x3F are delivered.
- rda_in held 1 and never dropped. Required: da_out stays high for exactly ACK_TIMEOUT cycles, timeout pulses once, and the next character starts normally.
- Assert rst while in STROBE with 3 characters queued. Required: da_out=0 next cycle, FIFO empty, no further strobes.
- Simultaneous wr_en and pop at full, and at empty. Required: count is correct and no data is lost or duplicated. Checked against a scoreboard over 200 random characters with random rda_in latency of 1..50 clocks.

Source files
------------

// File: rtl/terminal_pkg.sv
// Shared definitions for the terminal character path: sender FSM encoding,
// ASCII constants and the case-folding helper applied on FIFO write.
package terminal_pkg;

  localparam int unsigned CHAR_W = 7;

  localparam logic [CHAR_W-1:0] CR          = 7'h0D;
  localparam logic [CHAR_W-1:0] LOWER_A     = 7'h61;
  localparam logic [CHAR_W-1:0] LOWER_Z     = 7'h7A;
  localparam logic [CHAR_W-1:0] CASE_OFFSET = 7'h20;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetup   = 2'd1,
    StStrobe  = 2'd2,
    StRelease = 2'd3
  } sender_state_e;

  // Only a..z are folded; everything else, CR and DEL included, passes through.
  function automatic logic [CHAR_W-1:0] to_upper(input logic [CHAR_W-1:0] c);
    if (c >= LOWER_A && c <= LOWER_Z) begin
      return c - CASE_OFFSET;
    end
    return c;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous character FIFO. A pop frees a slot before a same-cycle push is
// judged, and a pop on an empty FIFO is ignored.
module char_fifo
  import terminal_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = CHAR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CntW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/terminal_char_sender.sv
// Queues ASCII characters and hands them to the video terminal one at a time
// using the rd/DA strobe handshake paced by the terminal's RDA flag.
module terminal_char_sender
  import terminal_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT  = 4096,
  parameter bit          UPCASE       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CHAR_W-1:0] wr_data,
  output logic              full,
  output logic              overflow,
  input  logic              rda_in,
  output logic [CHAR_W-1:0] rd_out,
  output logic              da_out,
  output logic              busy,
  output logic              timeout
);

  localparam int unsigned CntW      = $clog2(ACK_TIMEOUT + SETUP_CYCLES + 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] AckLast   = CntW'(ACK_TIMEOUT - 1);
  localparam int unsigned FifoCntW  = $clog2(FIFO_DEPTH) + 1;

  sender_state_e         state_q;
  logic [CntW-1:0]       cnt_q;
  logic [CHAR_W-1:0]     rd_out_q;
  logic                  da_q;
  logic                  timeout_q;
  logic                  overflow_q;
  logic                  rda_meta_q;
  logic                  rda_s_q;

  logic [CHAR_W-1:0]     wr_char;
  logic [CHAR_W-1:0]     fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [FifoCntW-1:0]   fifo_count;
  logic                  pop;

  always_comb begin
    wr_char = UPCASE ? to_upper(wr_data) : wr_data;
    pop     = (state_q == StIdle) && !fifo_empty && rda_s_q;
  end

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHAR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .din   (wr_char),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // rda_in comes from the terminal's own clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rda_meta_q <= 1'b0;
      rda_s_q    <= 1'b0;
    end else begin
      rda_meta_q <= rda_in;
      rda_s_q    <= rda_meta_q;
    end
  end

  // Only writes actually dropped count; a same-cycle pop makes room.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (wr_en && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_out_q  <= '0;
      da_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            rd_out_q <= fifo_dout;
            cnt_q    <= '0;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q   <= '0;
            da_q    <= 1'b1;
            state_q <= StStrobe;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStrobe: begin
          if (!rda_s_q) begin
            da_q    <= 1'b0;
            state_q <= StRelease;
          end else if (cnt_q == AckLast) begin
            da_q      <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StRelease;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRelease: begin
          if (rda_s_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd_out   = rd_out_q;
    da_out   = da_q;
    timeout  = timeout_q;
    overflow = overflow_q;
    full     = fifo_full;
    busy     = (state_q != StIdle) || (fifo_count != '0);
  end

endmodule

// File: tb/tb_terminal_char_sender.sv
// Self-checking bench for terminal_char_sender: directed scenarios plus a
// randomized stream checked against an in-order character scoreboard.
module tb_terminal_char_sender;

  localparam int unsigned Depth  = 16;
  localparam int unsigned Setup  = 2;
  localparam int unsigned AckTo  = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [6:0] wr_data;
  logic       full;
  logic       overflow;
  logic       rda_in;
  logic [6:0] rd_out;
  logic       da_out;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;
  bit stable_err = 1'b0;

  always #5 clk = ~clk;

  terminal_char_sender #(
    .FIFO_DEPTH   (Depth),
    .SETUP_CYCLES (Setup),
    .ACK_TIMEOUT  (AckTo),
    .UPCASE       (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .overflow (overflow),
    .rda_in   (rda_in),
    .rd_out   (rd_out),
    .da_out   (da_out),
    .busy     (busy),
    .timeout  (timeout)
  );

  function automatic logic [6:0] model_upper(input logic [6:0] c);
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic write_char(input logic [6:0] c);
    wr_en   = 1'b1;
    wr_data = c;
    tick();
    wr_en = 1'b0;
  endtask

  // Terminal model: wait for DA, hold RDA for lat clocks, drop it until DA falls,
  // keep it low gap more clocks, then raise it again.
  task automatic recv_char(input int lat, input int gap, output logic [6:0] c, output bit ok);
    int n;
    ok = 1'b1;
    c  = '0;
    n  = 0;
    while (da_out !== 1'b1 && n < 10000) begin
      tick();
      n++;
    end
    if (da_out !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    c = rd_out;
    repeat (lat) begin
      tick();
      if (da_out === 1'b1 && rd_out !== c) stable_err = 1'b1;
    end
    rda_in = 1'b0;
    n = 0;
    while (da_out !== 1'b0 && n < 20) begin
      tick();
      if (da_out === 1'b1 && rd_out !== c) stable_err = 1'b1;
      n++;
    end
    if (da_out !== 1'b0) ok = 1'b0;
    repeat (gap) tick();
    rda_in = 1'b1;
  endtask

  task automatic test_reset();
    rda_in = 1'b1;
    rst    = 1'b1;
    wr_en  = 1'b0;
    repeat (2) tick();
    n_checks++; if (rd_out !== 7'h00) begin n_errors++; $display("FAIL reset_rd_out got=%h want=00", rd_out); end
    n_checks++; if (da_out !== 1'b0) begin n_errors++; $display("FAIL reset_da got=%b want=0", da_out); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got=%b want=0", full); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    rda_in = 1'b1;
    do_reset();
    write_char(7'h41);
    n = 0;
    while (da_out !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++; if (da_out !== 1'b1) begin n_errors++; $display("FAIL basic_da_rise got=%b want=1", da_out); end
    n_checks++; if (rd_out !== 7'h41) begin n_errors++; $display("FAIL basic_rd_out got=%h want=41", rd_out); end
    rda_in = 1'b0;
    n = 0;
    while (da_out !== 1'b0 && n < 10) begin tick(); n++; end
    n_checks++; if (da_out !== 1'b0 || n > 3) begin
      n_errors++; $display("FAIL basic_da_fall clocks=%0d da=%b want<=3 and 0", n, da_out);
    end
    repeat (10 - n) tick();
    rda_in = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 6) begin tick(); n++; end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy got=%b want=0", busy); end
  endtask

  task automatic test_upcase();
    logic [6:0] in_c [6];
    logic [6:0] got;
    bit ok;
    in_c = '{7'h61, 7'h7A, 7'h7B, 7'h0D, 7'h7F, 7'h60};
    rda_in = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) write_char(in_c[i]);
    for (int i = 0; i < 6; i++) begin
      recv_char(2, 0, got, ok);
      n_checks++; if (!ok || got !== model_upper(in_c[i])) begin
        n_errors++; $display("FAIL upcase_%0d got=%h ok=%b want=%h", i, got, ok, model_upper(in_c[i]));
      end
    end
  endtask

  task automatic test_overflow();
    logic [6:0] got;
    bit ok;
    int rises;
    rda_in = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 17; i++) begin
      write_char(7'h30 + 7'(i));
      if (i == 15) begin
        n_checks++; if (full !== 1'b1 || overflow !== 1'b0) begin
          n_errors++; $display("FAIL ovf_full16 full=%b ovf=%b want full=1 ovf=0", full, overflow);
        end
      end
    end
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky17 got=%b want=1", overflow); end
    rda_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      recv_char(1, 0, got, ok);
      n_checks++; if (!ok || got !== 7'h30 + 7'(i)) begin
        n_errors++; $display("FAIL ovf_data_%0d got=%h ok=%b want=%h", i, got, ok, 7'h30 + 7'(i));
      end
    end
    rises = 0;
    repeat (40) begin tick(); if (da_out === 1'b1) rises++; end
    n_checks++; if (rises != 0) begin n_errors++; $display("FAIL ovf_extra_strobe cycles=%0d want=0", rises); end
    n_checks++; if (busy !== 1'b0 || overflow !== 1'b1) begin
      n_errors++; $display("FAIL ovf_end busy=%b ovf=%b want busy=0 ovf=1", busy, overflow);
    end
  endtask

  task automatic test_timeout();
    logic [6:0] got;
    bit ok;
    int hi;
    int pulses;
    int n;
    rda_in = 1'b1;
    do_reset();
    write_char(7'h55);
    write_char(7'h56);
    n = 0;
    while (da_out !== 1'b1 && n < 20) begin tick(); n++; end
    hi = 0;
    pulses = 0;
    while (da_out === 1'b1 && hi < AckTo + 100) begin
      if (timeout === 1'b1) pulses++;
      hi++;
      tick();
    end
    repeat (10) begin
      if (timeout === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (hi != AckTo) begin n_errors++; $display("FAIL timeout_da_len got=%0d want=%0d", hi, AckTo); end
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL timeout_pulses got=%0d want=1", pulses); end
    recv_char(1, 0, got, ok);
    n_checks++; if (!ok || got !== 7'h56) begin
      n_errors++; $display("FAIL timeout_next got=%h ok=%b want=56", got, ok);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int rises;
    rda_in = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) write_char(7'h44 + 7'(i));
    n = 0;
    while (da_out !== 1'b1 && n < 20) begin tick(); n++; end
    rst = 1'b1;
    tick();
    n_checks++; if (da_out !== 1'b0) begin n_errors++; $display("FAIL rstmid_da got=%b want=0", da_out); end
    n_checks++; if (busy !== 1'b0 || full !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_empty busy=%b full=%b want 0 0", busy, full);
    end
    rst = 1'b0;
    rises = 0;
    repeat (60) begin tick(); if (da_out === 1'b1) rises++; end
    n_checks++; if (rises != 0) begin n_errors++; $display("FAIL rstmid_strobes got=%0d want=0", rises); end
  endtask

  task automatic test_full_collision();
    logic [6:0] exp_c [$];
    logic [6:0] c;
    logic [6:0] got;
    bit ok;
    rda_in = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < Depth; i++) begin
      c = 7'($urandom);
      exp_c.push_back(model_upper(c));
      write_char(c);
    end
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL coll_full got=%b want=1", full); end
    // Terminal becomes ready; the first pop lands two sync clocks later, same edge as this write.
    rda_in = 1'b1;
    tick();
    tick();
    c = 7'($urandom);
    exp_c.push_back(model_upper(c));
    write_char(c);
    n_checks++; if (overflow !== 1'b0 || full !== 1'b1) begin
      n_errors++; $display("FAIL coll_accept ovf=%b full=%b want ovf=0 full=1", overflow, full);
    end
    for (int i = 0; i < Depth + 1; i++) begin
      recv_char(1, 0, got, ok);
      n_checks++; if (!ok || got !== exp_c[i]) begin
        n_errors++; $display("FAIL coll_data_%0d got=%h ok=%b want=%h", i, got, ok, exp_c[i]);
      end
    end
    // Write into an empty FIFO while the sender is idle and ready.
    repeat (4) tick();
    c = 7'($urandom);
    write_char(c);
    recv_char(1, 0, got, ok);
    n_checks++; if (!ok || got !== model_upper(c)) begin
      n_errors++; $display("FAIL coll_empty got=%h ok=%b want=%h", got, ok, model_upper(c));
    end
  endtask

  task automatic test_random();
    logic [6:0] exp_q [$];
    logic [6:0] want;
    int written;
    int delivered;
    bit abort;
    written   = 0;
    delivered = 0;
    abort     = 1'b0;
    stable_err = 1'b0;
    rda_in = 1'b1;
    do_reset();
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          int guard;
          logic [6:0] c;
          guard = 0;
          while ((written - delivered) >= int'(Depth) && guard < 20000 && !abort) begin
            tick();
            guard++;
          end
          if (abort || guard >= 20000) break;
          c = 7'($urandom);
          exp_q.push_back(model_upper(c));
          written++;
          write_char(c);
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        for (int k = 0; k < 200; k++) begin
          logic [6:0] got;
          bit ok;
          recv_char(int'($urandom_range(1, 50)), int'($urandom_range(0, 5)), got, ok);
          n_checks++;
          if (!ok || exp_q.size() == 0) begin
            n_errors++; $display("FAIL rand_handshake_%0d ok=%b queued=%0d want ok=1", k, ok, exp_q.size());
            abort = 1'b1;
            break;
          end
          want = exp_q.pop_front();
          delivered++;
          if (got !== want) begin
            n_errors++; $display("FAIL rand_data_%0d got=%h want=%h", k, got, want);
          end
        end
      end
    join
    repeat (10) tick();
    n_checks++; if (delivered != 200) begin n_errors++; $display("FAIL rand_count got=%0d want=200", delivered); end
    n_checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL rand_end ovf=%b busy=%b want 0 0", overflow, busy);
    end
    n_checks++; if (stable_err !== 1'b0) begin n_errors++; $display("FAIL rand_rd_stable got=%b want=0", stable_err); end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rda_in  = 1'b1;
    test_reset();
    test_basic();
    test_upcase();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_full_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
